// File: rtl/timer_counter_multi.sv
`default_nettype none
// ============================================================================
//  Module      : timer_counter_multi
//  Description : N-channel APB timer/counter. Every channel has a reload
//                register (TDR), a control register (TCR), sticky status
//                flags (TSR) and a counter (TCNT). The clock divider is a
//                shared 4-bit free-running prescaler that produces
//                pclk-domain tick enables, so no derived clocks exist.
//  Ports       : pclk, preset (async, active high)
//                psel/penable/pwrite/paddr/pwdata -> APB request
//                prdata/pready/pslverr            -> APB response
//                TMR_OVF/TMR_UDF                  -> sticky flags per channel
//                irq                              -> IE & (OVF | UDF) per channel
//  Address map : paddr = {channel[2:0], reg[1:0]}
//                reg 0 TDR rw, 1 TCR rw, 2 TSR rw1c, 3 TCNT ro
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_counter_multi #(
    parameter int NUM_CH     = 4,
    parameter int CNT_WIDTH  = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [NUM_CH-1:0]     TMR_OVF,
    output logic [NUM_CH-1:0]     TMR_UDF,
    output logic [NUM_CH-1:0]     irq
);

    localparam logic [1:0]           c_reg_tdr  = 2'd0;
    localparam logic [1:0]           c_reg_tcr  = 2'd1;
    localparam logic [1:0]           c_reg_tsr  = 2'd2;
    localparam logic [1:0]           c_reg_tcnt = 2'd3;
    localparam logic [CNT_WIDTH-1:0] c_cnt_max  = '1;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]           r_presc;
    logic [CNT_WIDTH-1:0] r_tdr [NUM_CH];
    logic [CNT_WIDTH-1:0] r_cnt [NUM_CH];
    logic [1:0]           r_cks [NUM_CH];
    logic [NUM_CH-1:0]    r_dn;
    logic [NUM_CH-1:0]    r_en;
    logic [NUM_CH-1:0]    r_ar;
    logic [NUM_CH-1:0]    r_ie;
    logic [NUM_CH-1:0]    r_ovf;
    logic [NUM_CH-1:0]    r_udf;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [2:0]           w_ch;
    logic [1:0]           w_reg;
    logic                 w_ch_ok;
    logic                 w_acc;
    logic                 w_wr;
    logic [3:0]           w_tick;
    logic [NUM_CH-1:0]    w_wr_tdr;
    logic [NUM_CH-1:0]    w_wr_tcr;
    logic [NUM_CH-1:0]    w_wr_tsr;
    logic [NUM_CH-1:0]    w_load;
    logic [NUM_CH-1:0]    w_step;
    logic [NUM_CH-1:0]    w_ovf_set;
    logic [NUM_CH-1:0]    w_udf_set;
    logic [CNT_WIDTH-1:0] w_cnt_nxt [NUM_CH];

    assign w_ch    = paddr[4:2];
    assign w_reg   = paddr[1:0];
    assign w_ch_ok = ({1'b0, w_ch} < 4'(NUM_CH));
    assign w_acc   = psel & penable;
    // Only legal writes reach the register file; rejected ones change nothing.
    assign w_wr    = w_acc & pwrite & w_ch_ok & (w_reg != c_reg_tcnt);

    assign pready  = w_acc;
    assign pslverr = w_acc & (~w_ch_ok | (pwrite & (w_reg == c_reg_tcnt)));

    // tick[k] is high for one pclk every 2^(k+1) cycles.
    assign w_tick[0] = r_presc[0];
    assign w_tick[1] = &r_presc[1:0];
    assign w_tick[2] = &r_presc[2:0];
    assign w_tick[3] = &r_presc[3:0];

    // ------------------------------------------------------------------
    // Per-channel next-state
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_wr_tdr[i]  = w_wr && (w_ch == 3'(i)) && (w_reg == c_reg_tdr);
            w_wr_tcr[i]  = w_wr && (w_ch == 3'(i)) && (w_reg == c_reg_tcr);
            w_wr_tsr[i]  = w_wr && (w_ch == 3'(i)) && (w_reg == c_reg_tsr);
            w_load[i]    = w_wr_tcr[i] & pwdata[7];
            w_step[i]    = r_en[i] & w_tick[r_cks[i]];
            w_cnt_nxt[i] = r_cnt[i];
            w_ovf_set[i] = 1'b0;
            w_udf_set[i] = 1'b0;
            if (w_load[i]) begin
                // A load swallows any tick arriving on the same edge.
                w_cnt_nxt[i] = r_tdr[i];
            end else if (w_step[i]) begin
                if (!r_dn[i]) begin
                    if (r_cnt[i] == c_cnt_max) begin
                        w_cnt_nxt[i] = r_ar[i] ? r_tdr[i] : '0;
                        w_ovf_set[i] = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + c_cnt_one;
                    end
                end else begin
                    if (r_cnt[i] == '0) begin
                        w_cnt_nxt[i] = r_ar[i] ? r_tdr[i] : c_cnt_max;
                        w_udf_set[i] = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] - c_cnt_one;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_presc <= 4'd0;
        end else begin
            r_presc <= r_presc + 4'd1;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_tdr[i] <= '0;
                r_cnt[i] <= '0;
                r_cks[i] <= 2'd0;
            end
            r_dn  <= '0;
            r_en  <= '0;
            r_ar  <= '0;
            r_ie  <= '0;
            r_ovf <= '0;
            r_udf <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_wr_tdr[i]) begin
                    r_tdr[i] <= pwdata[CNT_WIDTH-1:0];
                end
                if (w_wr_tcr[i]) begin
                    r_dn[i]  <= pwdata[5];
                    r_en[i]  <= pwdata[4];
                    r_ar[i]  <= pwdata[3];
                    r_ie[i]  <= pwdata[2];
                    r_cks[i] <= pwdata[1:0];
                end
                r_cnt[i] <= w_cnt_nxt[i];
                // A flag set on the same edge as its W1C clear survives.
                r_ovf[i] <= w_ovf_set[i] | (r_ovf[i] & ~(w_wr_tsr[i] & pwdata[0]));
                r_udf[i] <= w_udf_set[i] | (r_udf[i] & ~(w_wr_tsr[i] & pwdata[1]));
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path (zero outside a valid read access phase)
    // ------------------------------------------------------------------
    always_comb begin
        prdata = '0;
        if (w_acc && !pwrite && w_ch_ok) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_ch == 3'(i)) begin
                    case (w_reg)
                        c_reg_tdr:  prdata[CNT_WIDTH-1:0] = r_tdr[i];
                        c_reg_tcr:  prdata[5:0] = {r_dn[i], r_en[i], r_ar[i],
                                                   r_ie[i], r_cks[i]};
                        c_reg_tsr:  prdata[1:0] = {r_udf[i], r_ovf[i]};
                        default:    prdata[CNT_WIDTH-1:0] = r_cnt[i];
                    endcase
                end
            end
        end
    end

    assign TMR_OVF = r_ovf;
    assign TMR_UDF = r_udf;
    assign irq     = r_ie & (r_ovf | r_udf);

endmodule
`default_nettype wire

// File: tb/tb_timer_counter_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_counter_multi
//  Description : Directed self-checking bench for timer_counter_multi.
//                A 4-channel instance carries most of the stimulus; a
//                3-channel instance covers the out-of-range channel error.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_counter_multi;

    localparam logic [1:0] REG_TDR  = 2'd0;
    localparam logic [1:0] REG_TCR  = 2'd1;
    localparam logic [1:0] REG_TSR  = 2'd2;
    localparam logic [1:0] REG_TCNT = 2'd3;

    logic        pclk     = 1'b0;
    logic        preset   = 1'b1;
    logic        psel     = 1'b0;
    logic        penable  = 1'b0;
    logic        pwrite   = 1'b0;
    logic        psel3    = 1'b0;
    logic        penable3 = 1'b0;
    logic [4:0]  paddr    = '0;
    logic [15:0] pwdata   = '0;

    logic [15:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [3:0]  ovf;
    logic [3:0]  udf;
    logic [3:0]  irq;

    logic [15:0] prdata3;
    logic        pready3;
    logic        pslverr3;
    logic [2:0]  ovf3;
    logic [2:0]  udf3;
    logic [2:0]  irq3;

    int checks   = 0;
    int failures = 0;
    // Edges since reset release: equals the prescaler value at each negedge.
    int cyc      = 0;

    logic        e;
    logic [15:0] d;

    timer_counter_multi #(
        .NUM_CH(4), .CNT_WIDTH(16), .DATA_WIDTH(16), .ADDR_WIDTH(5)
    ) dut (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .TMR_OVF(ovf), .TMR_UDF(udf),
        .irq(irq)
    );

    timer_counter_multi #(
        .NUM_CH(3), .CNT_WIDTH(16), .DATA_WIDTH(16), .ADDR_WIDTH(5)
    ) dut3 (
        .pclk(pclk), .preset(preset), .psel(psel3), .penable(penable3),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata3),
        .pready(pready3), .pslverr(pslverr3), .TMR_OVF(ovf3), .TMR_UDF(udf3),
        .irq(irq3)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk or posedge preset) begin
        if (preset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full APB write; called at a negedge, returns at the negedge after the
    // write edge (the second rising edge after the call).
    task automatic wr(input logic [2:0] ch, input logic [1:0] r,
                      input logic [15:0] v, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = {ch, r}; pwdata = v;
        @(negedge pclk);
        penable = 1'b1;
        #1 err = pslverr;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic w(input logic [2:0] ch, input logic [1:0] r, input logic [15:0] v);
        logic tmp;
        wr(ch, r, v, tmp);
    endtask

    // Zero-time read: the access phase is held between edges, so reads never
    // shift the cycle accounting.
    task automatic rd(input logic [2:0] ch, input logic [1:0] r,
                      output logic [15:0] v, output logic err);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = {ch, r};
        #1 v = prdata; err = pslverr;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [2:0] ch,
                          input logic [1:0] r, input logic [15:0] exp);
        logic [15:0] v;
        logic        er;
        rd(ch, r, v, er);
        chk(tag, 32'(v), 32'(exp));
    endtask

    task automatic align(input int m, input int t);
        int n;
        n = 0;
        while ((cyc % m) != t && n < 64) begin
            @(negedge pclk);
            n++;
        end
        if ((cyc % m) != t) begin
            checks++;
            failures++;
            $error("FAIL align_timeout observed=%0d expected=%0d", cyc % m, t);
        end
    endtask

    initial begin
        @(negedge pclk);
        preset = 1'b0;

        // ---------------- T1: reset mid-count ----------------
        w(0, REG_TDR, 16'h0055); w(0, REG_TCR, 16'h0080); w(0, REG_TCR, 16'h0014);
        w(1, REG_TDR, 16'h0000); w(1, REG_TCR, 16'h0080); w(1, REG_TCR, 16'h0034);
        repeat (4) @(negedge pclk);
        chk("t1_pre_udf1", 32'(udf[1]), 1);
        chk("t1_pre_irq1", 32'(irq[1]), 1);
        #2 preset = 1'b1;
        #1;
        chk("t1_ovf", 32'(ovf), 0);
        chk("t1_udf", 32'(udf), 0);
        chk("t1_irq", 32'(irq), 0);
        @(negedge pclk);
        preset = 1'b0;
        chk_rd("t1_tdr0",  0, REG_TDR,  16'h0000);
        chk_rd("t1_tcr0",  0, REG_TCR,  16'h0000);
        chk_rd("t1_tcnt0", 0, REG_TCNT, 16'h0000);
        chk_rd("t1_tsr1",  1, REG_TSR,  16'h0000);
        chk_rd("t1_tcr1",  1, REG_TCR,  16'h0000);

        // ---------------- T2: count up to overflow ----------------
        w(0, REG_TDR, 16'hFFF0);
        w(0, REG_TCR, 16'h0080);
        chk_rd("t2_load",     0, REG_TCNT, 16'hFFF0);
        chk_rd("t2_load_rd0", 0, REG_TCR,  16'h0000);
        w(0, REG_TCR, 16'h0016);
        chk_rd("t2_tcr", 0, REG_TCR, 16'h0016);
        repeat (120) @(negedge pclk);
        chk_rd("t2_ffff", 0, REG_TCNT, 16'hFFFF);
        chk("t2_noovf", 32'(ovf[0]), 0);
        repeat (8) @(negedge pclk);
        chk_rd("t2_wrap", 0, REG_TCNT, 16'h0000);
        chk("t2_ovf", 32'(ovf[0]), 1);
        chk("t2_irq", 32'(irq[0]), 1);
        chk_rd("t2_tsr", 0, REG_TSR, 16'h0001);
        w(0, REG_TCR, 16'h0000);

        // ---------------- T3: auto-reload down ----------------
        w(1, REG_TDR, 16'h0003); w(1, REG_TCR, 16'h0080); w(1, REG_TCR, 16'h0038);
        repeat (2) @(negedge pclk);
        chk_rd("t3_cnt2", 1, REG_TCNT, 16'h0002);
        repeat (4) @(negedge pclk);
        chk_rd("t3_cnt0", 1, REG_TCNT, 16'h0000);
        chk("t3_noudf", 32'(udf[1]), 0);
        repeat (2) @(negedge pclk);
        chk_rd("t3_reload", 1, REG_TCNT, 16'h0003);
        chk("t3_udf", 32'(udf[1]), 1);
        chk("t3_irq_masked", 32'(irq[1]), 0);
        repeat (2) @(negedge pclk);
        chk_rd("t3_cnt2b", 1, REG_TCNT, 16'h0002);
        w(1, REG_TCR, 16'h0000);

        // ---------------- T4: W1C and set/clear race ----------------
        w(2, REG_TDR, 16'h0000); w(2, REG_TCR, 16'h0080); w(2, REG_TCR, 16'h0038);
        repeat (2) @(negedge pclk);
        chk("t4_udf_set", 32'(udf[2]), 1);
        w(2, REG_TCR, 16'h0000);
        w(2, REG_TDR, 16'hFFFF); w(2, REG_TCR, 16'h0080); w(2, REG_TCR, 16'h0018);
        repeat (2) @(negedge pclk);
        chk("t4_ovf_set", 32'(ovf[2]), 1);
        w(2, REG_TCR, 16'h0000);
        wr(2, REG_TSR, 16'h0001, e);
        chk("t4_w1c_err", 32'(e), 0);
        chk("t4_ovf_clr", 32'(ovf[2]), 0);
        chk("t4_udf_kept", 32'(udf[2]), 1);
        w(2, REG_TCR, 16'h0018);
        align(2, 0);
        w(2, REG_TSR, 16'h0001);
        chk("t4_race_ovf", 32'(ovf[2]), 1);
        chk("t4_race_udf", 32'(udf[2]), 1);
        w(2, REG_TCR, 16'h0000);
        w(2, REG_TSR, 16'h0002);
        chk("t4_udf_clr", 32'(udf[2]), 0);
        chk("t4_ovf_w0", 32'(ovf[2]), 1);

        // ---------------- T5: error responses ----------------
        w(0, REG_TDR, 16'h1234); w(0, REG_TCR, 16'h0080);
        wr(0, REG_TCNT, 16'h5555, e);
        chk("t5_tcnt_err", 32'(e), 1);
        chk_rd("t5_tcnt_kept", 0, REG_TCNT, 16'h1234);
        wr(5, REG_TDR, 16'hAAAA, e);
        chk("t5_ch5_wr_err", 32'(e), 1);
        rd(5, REG_TDR, d, e);
        chk("t5_ch5_rd_err", 32'(e), 1);
        chk("t5_ch5_rd_data", 32'(d), 0);
        rd(3, REG_TCR, d, e);
        chk("t5_ch3_ok", 32'(e), 0);
        psel3 = 1'b1; penable3 = 1'b1; pwrite = 1'b0; paddr = {3'd3, REG_TDR};
        #1;
        chk("t5_n3_err", 32'(pslverr3), 1);
        chk("t5_n3_data", 32'(prdata3), 0);
        chk("t5_n3_ready", 32'(pready3), 1);
        paddr = {3'd2, REG_TDR};
        #1;
        chk("t5_n3_ch2_ok", 32'(pslverr3), 0);
        psel3 = 1'b0; penable3 = 1'b0;

        // ---------------- T6: concurrency and load race ----------------
        w(2, REG_TDR, 16'h0100); w(2, REG_TCR, 16'h0080);
        w(3, REG_TDR, 16'h0200); w(3, REG_TCR, 16'h0080);
        align(16, 0);
        w(3, REG_TCR, 16'h0013);
        w(2, REG_TCR, 16'h0010);
        repeat (28) @(negedge pclk);
        chk_rd("t6_ch2", 2, REG_TCNT, 16'h010E);
        chk_rd("t6_ch3", 3, REG_TCNT, 16'h0202);
        align(16, 14);
        w(3, REG_TCR, 16'h0093);
        chk_rd("t6_load_race", 3, REG_TCNT, 16'h0200);
        chk_rd("t6_tcr3", 3, REG_TCR, 16'h0013);
        repeat (15) @(negedge pclk);
        chk_rd("t6_hold", 3, REG_TCNT, 16'h0200);
        @(negedge pclk);
        chk_rd("t6_next", 3, REG_TCNT, 16'h0201);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
